// File: rtl/id_bypass_stage_pkg.sv
// ---------------------------------------------------------------------------
// id_bypass_stage_pkg
// Shared defaults and helpers for the decode/bypass stage.
//   DATA_W / AW / PW : default register width, register address width and
//                      fetch-to-decode payload width.
//   STG_EX/MEM/WB    : producer stage indices, 0 is the nearest producer.
//   src_sel_e        : operand source chosen by a bypass mux.
//   sat_inc16        : 16-bit saturating increment for the stall counter.
// ---------------------------------------------------------------------------
package id_bypass_stage_pkg;

  localparam int DATA_W = 32;
  localparam int AW     = 5;
  localparam int PW     = 64;

  localparam int STG_EX  = 0;
  localparam int STG_MEM = 1;
  localparam int STG_WB  = 2;

  localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

  typedef enum logic [1:0] {
    SEL_RF    = 2'd0,
    SEL_FWD   = 2'd1,
    SEL_BLOCK = 2'd2
  } src_sel_e;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    logic [15:0] r;
    if (v == STALL_CNT_MAX) begin
      r = v;
    end else begin
      r = v + 16'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/id_bypass_stage_bypass_mux.sv
// ---------------------------------------------------------------------------
// bypass_mux
// Priority forwarding for one source operand port.
//   src_addr_i / src_rd_i   : register index and "operand is read" flag
//   rf_rdata_i              : register file data for this port
//   stg_*_i                 : producer stage status, index 0 nearest
//   value_o                 : forwarded or register-file operand
//   blocked_o               : nearest matching producer has no result yet
// ---------------------------------------------------------------------------
module bypass_mux #(
  parameter int DATA_W = id_bypass_stage_pkg::DATA_W,
  parameter int AW     = id_bypass_stage_pkg::AW,
  parameter int NSTG   = 3
) (
  input  logic [AW-1:0]          src_addr_i,
  input  logic                   src_rd_i,
  input  logic [DATA_W-1:0]      rf_rdata_i,
  input  logic [NSTG-1:0]        stg_valid_i,
  input  logic [NSTG-1:0]        stg_wen_i,
  input  logic [NSTG*AW-1:0]     stg_dest_i,
  input  logic [NSTG*DATA_W-1:0] stg_data_i,
  input  logic [NSTG-1:0]        stg_data_ok_i,
  output logic [DATA_W-1:0]      value_o,
  output logic                   blocked_o
);
  import id_bypass_stage_pkg::*;

  src_sel_e          sel_s;
  logic [DATA_W-1:0] fwd_data_s;
  logic              found_s;

  // Scan producers nearest-first; the first match decides the source.
  // Register 0 is never forwarded because it is hardwired to zero.
  always_comb begin
    sel_s      = SEL_RF;
    fwd_data_s = {DATA_W{1'b0}};
    found_s    = 1'b0;
    for (int s = 0; s < NSTG; s++) begin
      if (!found_s && src_rd_i && (src_addr_i != {AW{1'b0}}) &&
          stg_valid_i[s] && stg_wen_i[s] &&
          (stg_dest_i[s*AW +: AW] == src_addr_i)) begin
        found_s = 1'b1;
        if (stg_data_ok_i[s]) begin
          sel_s      = SEL_FWD;
          fwd_data_s = stg_data_i[s*DATA_W +: DATA_W];
        end else begin
          sel_s      = SEL_BLOCK;
        end
      end else begin
        found_s = found_s;
      end
    end
  end

  // Drive the operand and the block flag from the selected source.
  always_comb begin
    value_o   = rf_rdata_i;
    blocked_o = 1'b0;
    case (sel_s)
      SEL_RF:    value_o = rf_rdata_i;
      SEL_FWD:   value_o = fwd_data_s;
      SEL_BLOCK: blocked_o = 1'b1;
      default:   blocked_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/id_bypass_stage.sv
// ---------------------------------------------------------------------------
// id_bypass_stage
// Decode stage holding one fetch payload, forwarding operands from the
// downstream producers and stalling on results not yet available.
//   clk, reset (async, active-high)
//   fs_to_ds_valid/fs_to_ds_bus : upstream payload, ds_allowin back-pressure
//   es_allowin                  : downstream accepts
//   ds_to_es_valid/ds_bus       : held payload and its go signal
//   src_addr/src_rd/rf_rdata    : per-port operand requests and RF data
//   stg_valid/wen/dest/data/data_ok : producer stage status (0 = EX)
//   flush                       : kill the held payload
//   src_value                   : bypassed operands
//   stall_cnt                   : saturating hazard-stall cycle count
// ---------------------------------------------------------------------------
module id_bypass_stage #(
  parameter int DATA_W = id_bypass_stage_pkg::DATA_W,
  parameter int AW     = id_bypass_stage_pkg::AW,
  parameter int NSRC   = 2,
  parameter int NSTG   = 3,
  parameter int PW     = id_bypass_stage_pkg::PW
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fs_to_ds_valid,
  input  logic [PW-1:0]          fs_to_ds_bus,
  output logic                   ds_allowin,
  input  logic                   es_allowin,
  output logic                   ds_to_es_valid,
  output logic [PW-1:0]          ds_bus,
  input  logic [NSRC*AW-1:0]     src_addr,
  input  logic [NSRC-1:0]        src_rd,
  input  logic [NSRC*DATA_W-1:0] rf_rdata,
  input  logic [NSTG-1:0]        stg_valid,
  input  logic [NSTG-1:0]        stg_wen,
  input  logic [NSTG*AW-1:0]     stg_dest,
  input  logic [NSTG*DATA_W-1:0] stg_data,
  input  logic [NSTG-1:0]        stg_data_ok,
  input  logic                   flush,
  output logic [NSRC*DATA_W-1:0] src_value,
  output logic [15:0]            stall_cnt
);
  import id_bypass_stage_pkg::*;

  logic            ds_valid_q, ds_valid_d;
  logic [PW-1:0]   ds_bus_q,   ds_bus_d;
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic [NSRC-1:0] blocked_s;
  logic            ds_ready_go_s;

  for (genvar p = 0; p < NSRC; p++) begin : g_port
    bypass_mux #(
      .DATA_W (DATA_W),
      .AW     (AW),
      .NSTG   (NSTG)
    ) u_bypass_mux (
      .src_addr_i    (src_addr[p*AW +: AW]),
      .src_rd_i      (src_rd[p]),
      .rf_rdata_i    (rf_rdata[p*DATA_W +: DATA_W]),
      .stg_valid_i   (stg_valid),
      .stg_wen_i     (stg_wen),
      .stg_dest_i    (stg_dest),
      .stg_data_i    (stg_data),
      .stg_data_ok_i (stg_data_ok),
      .value_o       (src_value[p*DATA_W +: DATA_W]),
      .blocked_o     (blocked_s[p])
    );
  end

  assign ds_ready_go_s  = ~|blocked_s;
  assign ds_allowin     = ~ds_valid_q | (ds_ready_go_s & es_allowin);
  // A flushed payload must not escape in the same cycle it is killed.
  assign ds_to_es_valid = ds_valid_q & ds_ready_go_s & ~flush;
  assign ds_bus         = ds_bus_q;
  assign stall_cnt      = stall_cnt_q;

  // Next-state for the held payload and the stall counter.
  always_comb begin
    ds_valid_d  = ds_valid_q;
    ds_bus_d    = ds_bus_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      ds_valid_d = 1'b0;
    end else if (ds_allowin) begin
      ds_valid_d = fs_to_ds_valid;
    end else begin
      ds_valid_d = ds_valid_q;
    end
    if (fs_to_ds_valid && ds_allowin && !flush) begin
      ds_bus_d = fs_to_ds_bus;
    end else begin
      ds_bus_d = ds_bus_q;
    end
    if (ds_valid_q && !ds_ready_go_s && !flush) begin
      stall_cnt_d = sat_inc16(stall_cnt_q);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // State registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ds_valid_q  <= 1'b0;
      ds_bus_q    <= {PW{1'b0}};
      stall_cnt_q <= 16'd0;
    end else begin
      ds_valid_q  <= ds_valid_d;
      ds_bus_q    <= ds_bus_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_id_bypass_stage.sv
module tb_id_bypass_stage;
  localparam int DW   = 32;
  localparam int AW   = 5;
  localparam int NSRC = 2;
  localparam int NSTG = 3;
  localparam int PW   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 fs_to_ds_valid;
  logic [PW-1:0]        fs_to_ds_bus;
  logic                 ds_allowin;
  logic                 es_allowin;
  logic                 ds_to_es_valid;
  logic [PW-1:0]        ds_bus;
  logic [NSRC*AW-1:0]   src_addr;
  logic [NSRC-1:0]      src_rd;
  logic [NSRC*DW-1:0]   rf_rdata;
  logic [NSTG-1:0]      stg_valid, stg_wen, stg_data_ok;
  logic [NSTG*AW-1:0]   stg_dest;
  logic [NSTG*DW-1:0]   stg_data;
  logic                 flush;
  logic [NSRC*DW-1:0]   src_value;
  logic [15:0]          stall_cnt;

  // Unpacked views driven by the stimulus code
  logic          sv [NSTG];
  logic          sw [NSTG];
  logic          sok[NSTG];
  logic [AW-1:0] sd [NSTG];
  logic [DW-1:0] sdat[NSTG];
  logic [AW-1:0] sa [NSRC];
  logic          srd[NSRC];
  logic [DW-1:0] rf [NSRC];

  always_comb begin
    stg_valid = '0; stg_wen = '0; stg_data_ok = '0; stg_dest = '0; stg_data = '0;
    src_addr = '0; src_rd = '0; rf_rdata = '0;
    for (int s = 0; s < NSTG; s++) begin
      stg_valid[s] = sv[s];
      stg_wen[s] = sw[s];
      stg_data_ok[s] = sok[s];
      stg_dest[s*AW +: AW] = sd[s];
      stg_data[s*DW +: DW] = sdat[s];
    end
    for (int p = 0; p < NSRC; p++) begin
      src_addr[p*AW +: AW] = sa[p];
      src_rd[p] = srd[p];
      rf_rdata[p*DW +: DW] = rf[p];
    end
  end

  id_bypass_stage #(.DATA_W(DW), .AW(AW), .NSRC(NSRC), .NSTG(NSTG), .PW(PW)) dut (
    .clk(clk), .reset(reset),
    .fs_to_ds_valid(fs_to_ds_valid), .fs_to_ds_bus(fs_to_ds_bus),
    .ds_allowin(ds_allowin), .es_allowin(es_allowin),
    .ds_to_es_valid(ds_to_es_valid), .ds_bus(ds_bus),
    .src_addr(src_addr), .src_rd(src_rd), .rf_rdata(rf_rdata),
    .stg_valid(stg_valid), .stg_wen(stg_wen), .stg_dest(stg_dest),
    .stg_data(stg_data), .stg_data_ok(stg_data_ok), .flush(flush),
    .src_value(src_value), .stall_cnt(stall_cnt)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit          m_valid;
  logic [63:0] m_bus;
  int          m_cnt;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Operand for one port from the rule: nearest writer of the register wins,
  // a writer without its result blocks, register 0 always reads the RF.
  task automatic model_port(input int p, output logic [DW-1:0] v, output bit blk);
    int hit;
    hit = -1;
    blk = 1'b0;
    v = rf[p];
    if (srd[p] && sa[p] != 0) begin
      for (int s = 0; s < NSTG; s++)
        if (hit < 0 && sv[s] && sw[s] && sd[s] == sa[p]) hit = s;
      if (hit >= 0) begin
        if (sok[hit]) v = sdat[hit];
        else blk = 1'b1;
      end
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_bus = 64'd0;
    m_cnt = 0;
  endtask

  // Called in the low clock phase with inputs set; checks, then advances one edge.
  task automatic do_cycle(input bit en);
    logic [DW-1:0] v [NSRC];
    bit b [NSRC];
    bit ready, allow;
    #1;
    ready = 1'b1;
    for (int p = 0; p < NSRC; p++) begin
      model_port(p, v[p], b[p]);
      if (b[p]) ready = 1'b0;
    end
    allow = !m_valid || (ready && es_allowin);
    if (en) begin
      chk("ds_allowin", ds_allowin, allow);
      chk("ds_to_es_valid", ds_to_es_valid, m_valid && ready && !flush);
      chk("ds_bus", ds_bus, m_bus);
      chk("stall_cnt", stall_cnt, m_cnt);
      for (int p = 0; p < NSRC; p++)
        if (!b[p]) chk("src_value", src_value[p*DW +: DW], v[p]);
    end
    if (m_valid && !ready && !flush && m_cnt < 65535) m_cnt++;
    if (fs_to_ds_valid && allow && !flush) m_bus = fs_to_ds_bus;
    if (flush) m_valid = 1'b0;
    else if (allow) m_valid = fs_to_ds_valid;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_stages();
    for (int s = 0; s < NSTG; s++) begin
      sv[s] = 1'b0; sw[s] = 1'b0; sok[s] = 1'b0; sd[s] = '0; sdat[s] = '0;
    end
  endtask

  task automatic clear_all();
    clear_stages();
    for (int p = 0; p < NSRC; p++) begin
      sa[p] = '0; srd[p] = 1'b0; rf[p] = '0;
    end
    fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0; es_allowin = 1'b1; flush = 1'b0;
  endtask

  task automatic set_stage(input int s, input bit v, input bit w, input logic [AW-1:0] d,
                           input logic [DW-1:0] dat, input bit ok);
    sv[s] = v; sw[s] = w; sd[s] = d; sdat[s] = dat; sok[s] = ok;
  endtask

  task automatic load_payload(input logic [63:0] bus);
    fs_to_ds_valid = 1'b1;
    fs_to_ds_bus = bus;
    do_cycle(1'b1);
    fs_to_ds_valid = 1'b0;
  endtask

  typedef struct {
    logic [2:0]    v, w, ok;
    logic [AW-1:0] d0, d1, d2;
    logic          rd;
    logic [AW-1:0] a;
    logic [DW-1:0] exp;
    logic          rdy;
  } vec_t;

  vec_t vecs[12];
  int   saved_cnt;

  initial begin
    vecs[0]  = '{3'b001, 3'b001, 3'b001, 5'd5, 5'd0, 5'd0, 1'b1, 5'd5, 32'h1111, 1'b1};
    vecs[1]  = '{3'b011, 3'b011, 3'b010, 5'd5, 5'd5, 5'd0, 1'b1, 5'd5, 32'h0,    1'b0};
    vecs[2]  = '{3'b001, 3'b001, 3'b001, 5'd6, 5'd0, 5'd0, 1'b1, 5'd5, 32'hF0F0, 1'b1};
    vecs[3]  = '{3'b110, 3'b110, 3'b110, 5'd0, 5'd5, 5'd5, 1'b1, 5'd5, 32'h2222, 1'b1};
    vecs[4]  = '{3'b100, 3'b100, 3'b100, 5'd0, 5'd0, 5'd5, 1'b1, 5'd5, 32'h3333, 1'b1};
    vecs[5]  = '{3'b001, 3'b001, 3'b001, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 32'hF0F0, 1'b1};
    vecs[6]  = '{3'b111, 3'b111, 3'b111, 5'd0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hF0F0, 1'b1};
    vecs[7]  = '{3'b011, 3'b010, 3'b011, 5'd5, 5'd5, 5'd0, 1'b1, 5'd5, 32'h2222, 1'b1};
    vecs[8]  = '{3'b100, 3'b101, 3'b101, 5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 32'h3333, 1'b1};
    vecs[9]  = '{3'b100, 3'b100, 3'b000, 5'd0, 5'd0, 5'd5, 1'b1, 5'd5, 32'h0,    1'b0};
    vecs[10] = '{3'b001, 3'b001, 3'b000, 5'd5, 5'd0, 5'd0, 1'b0, 5'd5, 32'hF0F0, 1'b1};
    vecs[11] = '{3'b101, 3'b101, 3'b001, 5'd5, 5'd0, 5'd5, 1'b1, 5'd5, 32'h1111, 1'b1};

    reset = 1'b1;
    clear_all();
    model_reset();
    #3;
    chk("reset_allowin", ds_allowin, 1'b1);
    chk("reset_to_es_valid", ds_to_es_valid, 1'b0);
    chk("reset_ds_bus", ds_bus, 64'd0);
    chk("reset_stall_cnt", stall_cnt, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // EX forwards r5 with zero added latency
    load_payload(64'hA5A5_0001_0000_1000);
    set_stage(0, 1'b1, 1'b1, 5'd5, 32'h1234, 1'b1);
    sa[0] = 5'd5; srd[0] = 1'b1;
    #1;
    chk("ex_fwd_value", src_value[DW-1:0], 32'h1234);
    chk("ex_fwd_go", ds_to_es_valid, 1'b1);
    do_cycle(1'b1);
    clear_stages();
    srd[0] = 1'b0;

    // Load in EX blocks even with MEM holding r5, then releases from MEM
    load_payload(64'hA5A5_0002_0000_1004);
    set_stage(0, 1'b1, 1'b1, 5'd5, 32'h0, 1'b0);
    set_stage(1, 1'b1, 1'b1, 5'd5, 32'hAAAA, 1'b1);
    sa[0] = 5'd5; srd[0] = 1'b1;
    #1;
    chk("load_block_go", ds_to_es_valid, 1'b0);
    do_cycle(1'b1);
    chk("load_block_cnt", stall_cnt, 16'd1);
    clear_stages();
    set_stage(1, 1'b1, 1'b1, 5'd5, 32'hBEEF, 1'b1);
    #1;
    chk("load_release_value", src_value[DW-1:0], 32'hBEEF);
    chk("load_release_go", ds_to_es_valid, 1'b1);
    do_cycle(1'b1);
    clear_stages();
    srd[0] = 1'b0;

    // Port 1 reading r0 never forwards
    load_payload(64'hA5A5_0003_0000_1008);
    for (int s = 0; s < NSTG; s++) set_stage(s, 1'b1, 1'b1, 5'd0, 32'h5000 + s, 1'b1);
    sa[1] = 5'd0; srd[1] = 1'b1; rf[1] = 32'hCAFE;
    #1;
    chk("r0_value", src_value[2*DW-1:DW], 32'hCAFE);
    chk("r0_go", ds_to_es_valid, 1'b1);
    do_cycle(1'b1);
    clear_stages();
    srd[1] = 1'b0;

    // Downstream back-pressure holds the payload and does not count as stall
    load_payload(64'hB0B0_0004_0000_100C);
    es_allowin = 1'b0;
    fs_to_ds_valid = 1'b1; fs_to_ds_bus = 64'hC0C0_0005_0000_1010;
    saved_cnt = m_cnt;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_ds_bus", ds_bus, 64'hB0B0_0004_0000_100C);
      chk("bp_allowin", ds_allowin, 1'b0);
      chk("bp_stall_cnt", stall_cnt, saved_cnt[15:0]);
      do_cycle(1'b1);
    end

    // Flush a stalled payload while upstream offers a new one
    es_allowin = 1'b1; fs_to_ds_valid = 1'b0;
    set_stage(0, 1'b1, 1'b1, 5'd5, 32'h0, 1'b0);
    sa[0] = 5'd5; srd[0] = 1'b1;
    do_cycle(1'b1);
    flush = 1'b1; fs_to_ds_valid = 1'b1; fs_to_ds_bus = 64'hD0D0_0006_0000_1014;
    saved_cnt = m_cnt;
    #1;
    chk("flush_go", ds_to_es_valid, 1'b0);
    do_cycle(1'b1);
    flush = 1'b0; fs_to_ds_valid = 1'b0;
    #1;
    chk("flush_empty", ds_allowin, 1'b1);
    chk("flush_go_after", ds_to_es_valid, 1'b0);
    chk("flush_stall_cnt", stall_cnt, saved_cnt[15:0]);
    do_cycle(1'b1);
    clear_stages();
    srd[0] = 1'b0;

    // Table of priority/selection cases on port 0 with a held payload
    load_payload(64'hE0E0_0007_0000_1018);
    es_allowin = 1'b0;
    rf[0] = 32'hF0F0;
    for (int i = 0; i < 12; i++) begin
      set_stage(0, vecs[i].v[0], vecs[i].w[0], vecs[i].d0, 32'h1111, vecs[i].ok[0]);
      set_stage(1, vecs[i].v[1], vecs[i].w[1], vecs[i].d1, 32'h2222, vecs[i].ok[1]);
      set_stage(2, vecs[i].v[2], vecs[i].w[2], vecs[i].d2, 32'h3333, vecs[i].ok[2]);
      sa[0] = vecs[i].a; srd[0] = vecs[i].rd;
      #1;
      chk("vec_go", ds_to_es_valid, vecs[i].rdy);
      if (vecs[i].rdy) chk("vec_value", src_value[DW-1:0], vecs[i].exp);
      do_cycle(1'b1);
    end
    clear_all();

    // Randomised traffic against the model
    for (int i = 0; i < 400; i++) begin
      for (int s = 0; s < NSTG; s++)
        set_stage(s, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), $urandom, $urandom_range(0, 3) != 0);
      for (int p = 0; p < NSRC; p++) begin
        sa[p] = 5'($urandom_range(0, 3)); srd[p] = 1'($urandom_range(0, 1)); rf[p] = $urandom;
      end
      fs_to_ds_valid = 1'($urandom_range(0, 1));
      fs_to_ds_bus = {$urandom, $urandom};
      es_allowin = $urandom_range(0, 3) != 0;
      flush = $urandom_range(0, 7) == 0;
      do_cycle(1'b1);
    end
    clear_all();

    // Long stall saturates the counter
    load_payload(64'hF1F1_0008_0000_101C);
    set_stage(0, 1'b1, 1'b1, 5'd5, 32'h0, 1'b0);
    sa[0] = 5'd5; srd[0] = 1'b1;
    for (int i = 0; i < 70000; i++) do_cycle(1'b0);
    #1;
    chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
    chk("sat_go", ds_to_es_valid, 1'b0);

    // Asynchronous reset in the middle of the stall
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_allowin", ds_allowin, 1'b1);
    chk("async_rst_go", ds_to_es_valid, 1'b0);
    chk("async_rst_bus", ds_bus, 64'd0);
    chk("async_rst_cnt", stall_cnt, 16'd0);
    model_reset();
    clear_all();
    @(negedge clk);
    reset = 1'b0;
    load_payload(64'h1234_5678_9ABC_DEF0);
    #1;
    chk("post_rst_accept", ds_bus, 64'h1234_5678_9ABC_DEF0);
    chk("post_rst_go", ds_to_es_valid, 1'b1);
    do_cycle(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_bypass_stage.md
ID_BYPASS_STAGE -- requirements
Module: id_bypass_stage

Interface
REQ-001 Parameter DATA_W, 32, register data width.
REQ-002 Parameter AW, 5, register address width; address 0 is the hardwired zero register.
REQ-003 Parameter NSRC, 2, number of source operand read ports (1..3).
REQ-004 Parameter NSTG, 3, number of downstream producer stages; index 0 is nearest (EX), NSTG-1 farthest (WB).
REQ-005 Parameter PW, 64, width of the fetch-to-decode payload.
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 fs_to_ds_valid  in  1  upstream payload valid.
REQ-009 fs_to_ds_bus  in  PW  upstream payload {inst, pc}.
REQ-010 ds_allowin  out  1  stage can accept a payload this cycle.
REQ-011 es_allowin  in  1  downstream can accept.
REQ-012 ds_to_es_valid  out  1  held payload valid and hazard-free.
REQ-013 ds_bus  out  PW  held payload register.
REQ-014 src_addr  in  NSRC*AW  per-port source register index (decoded from ds_bus).
REQ-015 src_rd  in  NSRC  per-port "operand actually read".
REQ-016 rf_rdata  in  NSRC*DATA_W  register file read data per port.
REQ-017 stg_valid, stg_wen  in  NSTG each  producer valid / writes register.
REQ-018 stg_dest  in  NSTG*AW  producer destination.
REQ-019 stg_data  in  NSTG*DATA_W  producer result.
REQ-020 stg_data_ok  in  NSTG  producer result available this cycle (0 for a load still in EX).
REQ-021 flush  in  1  redirect/branch kill of the held payload.
REQ-022 src_value  out  NSRC*DATA_W  bypassed operand per port.
REQ-023 stall_cnt  out  16  saturating count of hazard-stall cycles.

Function
REQ-024 Stage SHALL hold one payload in ds_bus_r with valid bit ds_valid; ds_allowin = !ds_valid | (ds_ready_go & es_allowin).
REQ-025 When ds_allowin, ds_valid SHALL load fs_to_ds_valid; ds_bus_r SHALL load only when fs_to_ds_valid & ds_allowin.
REQ-026 flush SHALL clear ds_valid next cycle and override any simultaneous load; ds_to_es_valid SHALL be 0 in the flush cycle.
REQ-027 Per port p, stage s matches when src_rd[p] & src_addr[p]!=0 & stg_valid[s] & stg_wen[s] & stg_dest[s]==src_addr[p].
REQ-028 Lowest-index matching stage wins; if it has stg_data_ok, src_value[p] = its stg_data, else port p SHALL be blocked.
REQ-029 No match: src_value[p] = rf_rdata[p]; addr 0 SHALL yield rf_rdata (never forwarded).
REQ-030 ds_ready_go SHALL be 0 iff any port blocked; ds_to_es_valid = ds_valid & ds_ready_go, combinational, zero added latency.
REQ-031 stall_cnt SHALL increment each cycle with ds_valid & !ds_ready_go & !flush, saturating at 16'hFFFF.
REQ-032 Outputs SHALL depend on stg_* combinationally; only ds_valid, ds_bus_r, stall_cnt are state.

Reset
REQ-033 On reset assertion, immediately: ds_valid=0, ds_bus_r=0, stall_cnt=0; hence ds_allowin=1, ds_to_es_valid=0.
REQ-034 Reset mid-stall SHALL discard the held payload; first post-reset accept occurs on the first clk edge after deassertion.

Structure
REQ-035 Shared package SHALL hold DATA_W, AW, PW defaults and the stage-index constants (STG_EX=0, STG_MEM=1, STG_WB=2).
REQ-036 One sub-module, bypass_mux, SHALL implement per-port priority match/select and be instantiated NSRC times via generate.

Verification
REQ-037 EX writes r5 data_ok=1 value 32'h1234, port0 reads r5 -> src_value0=32'h1234, ds_to_es_valid=1 same cycle.
REQ-038 EX r5 data_ok=0 (load), MEM r5 32'hAAAA -> blocked, ds_to_es_valid=0, stall_cnt +1; next cycle load in MEM data_ok=1 32'hBEEF -> src_value0=32'hBEEF, released.
REQ-039 Port1 addr 0, all stages write r0 -> src_value1=rf_rdata1, no stall.
REQ-040 Held payload stalled, flush=1 with fs_to_ds_valid=1 -> next cycle ds_valid=0, stall_cnt unchanged.
REQ-041 es_allowin=0 for 3 cycles with valid payload -> ds_bus stable, ds_allowin=0, stall_cnt unchanged.
REQ-042 Force 70000 stall cycles -> stall_cnt=16'hFFFF; assert reset mid-run -> all state zero asynchronously.
